// File: rtl/add_norm_seq.sv
// Post-add normalizer for IEEE754 single: takes the raw CLA sum/carry and exponent,
// left-shifts one bit per cycle until the hidden bit is set (or the denormal floor is hit).
module add_norm_seq (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iValid,
    input  logic [23:0] iS,
    input  logic        iC,
    input  logic [7:0]  iE,
    input  logic        iSign,
    output logic        oReady,
    output logic        oValid,
    output logic [31:0] oF,
    output logic        oOvf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q, state_d;
    logic [23:0] mant_q, mant_d;
    logic [7:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        ovf_q, ovf_d;
    logic        valid_q;
    logic [31:0] f_q;
    logic        ovf_out_q;
    logic        load_out;
    logic [7:0]  exp_dec;

    always_comb begin
        state_d  = state_q;
        mant_d   = mant_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        load_out = 1'b0;
        exp_dec  = exp_q - 8'd1;
        case (state_q)
            IDLE: begin
                if (iValid) begin
                    sign_d   = iSign;
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                    load_out = 1'b1;
                    if (iE == 8'hFF || (iC && iE == 8'hFE)) begin
                        exp_d  = 8'hFF;
                        mant_d = 24'h0;
                        ovf_d  = 1'b1;
                    end else if (iC) begin
                        // carry-out: renormalize right by one, LSB is truncated
                        mant_d = {1'b1, iS[23:1]};
                        exp_d  = iE + 8'd1;
                    end else if (iS == 24'h0) begin
                        mant_d = 24'h0;
                        exp_d  = 8'h0;
                    end else if (iS[23]) begin
                        mant_d = iS;
                        exp_d  = iE;
                    end else if (iE <= 8'd1) begin
                        mant_d = iS;
                        exp_d  = 8'h0;
                    end else begin
                        mant_d   = iS;
                        exp_d    = iE;
                        state_d  = SHIFT;
                        load_out = 1'b0;
                    end
                end
            end
            SHIFT: begin
                mant_d = mant_q << 1;
                exp_d  = exp_dec;
                if (mant_q[22]) begin
                    state_d  = DONE;
                    load_out = 1'b1;
                end else if (exp_dec == 8'd1) begin
                    // reached the denormal floor before normalizing
                    exp_d    = 8'h0;
                    state_d  = DONE;
                    load_out = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q   <= IDLE;
            mant_q    <= 24'h0;
            exp_q     <= 8'h0;
            sign_q    <= 1'b0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            f_q       <= 32'h0;
            ovf_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            sign_q  <= sign_d;
            ovf_q   <= ovf_d;
            valid_q <= load_out;
            if (load_out) begin
                f_q       <= {sign_d, exp_d, mant_d[22:0]};
                ovf_out_q <= ovf_d;
            end
        end
    end

    assign oReady = (state_q == IDLE);
    assign oValid = valid_q;
    assign oF     = f_q;
    assign oOvf   = ovf_out_q;

endmodule

// File: tb/tb_add_norm_seq.sv
// Directed checks of the add_norm_seq normalizer against hand-computed results.
module tb_add_norm_seq;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic [23:0] iS;
    logic        iC;
    logic [7:0]  iE;
    logic        iSign;
    logic        oReady;
    logic        oValid;
    logic [31:0] oF;
    logic        oOvf;

    int vecs = 0;
    int errs = 0;

    add_norm_seq dut (
        .iClk(iClk), .iRst(iRst), .iValid(iValid), .iS(iS), .iC(iC), .iE(iE),
        .iSign(iSign), .oReady(oReady), .oValid(oValid), .oF(oF), .oOvf(oOvf)
    );

    always #5 iClk = ~iClk;

    // Issue one request at the next negedge, then wait (bounded) for oValid.
    // With noise set, iValid stays high with junk operands while the op is in flight.
    task automatic send(input logic [23:0] s, input logic c, input logic [7:0] e,
                        input logic sg, input bit noise,
                        output int lat, output logic [31:0] f, output logic ovf);
        @(negedge iClk);
        iValid = 1'b1; iS = s; iC = c; iE = e; iSign = sg;
        @(posedge iClk);
        #1;
        if (noise) begin
            iS = 24'h800000; iC = 1'b1; iE = 8'd5; iSign = 1'b1;
        end else begin
            iValid = 1'b0;
        end
        lat = -1;
        f   = 32'hx;
        ovf = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(negedge iClk);
            if (oValid) begin
                lat = n; f = oF; ovf = oOvf;
                break;
            end
        end
        iValid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge iClk);
        iRst = 1'b1; iValid = 1'b1; iS = 24'h800000; iC = 1'b0; iE = 8'd127; iSign = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        vecs++; if (oValid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", oValid); end
        iRst = 1'b0; iValid = 1'b0;
        vecs++; if (oReady !== 1'b1) begin errs++; $display("FAIL rst_ready got %b want 1", oReady); end
        vecs++; if (oF !== 32'h0) begin errs++; $display("FAIL rst_oF got %h want 00000000", oF); end
        vecs++; if (oOvf !== 1'b0) begin errs++; $display("FAIL rst_ovf got %b want 0", oOvf); end
        @(negedge iClk);
        vecs++; if (oValid !== 1'b0) begin errs++; $display("FAIL rst_no_result got %b want 0", oValid); end
    endtask

    task automatic test_one;
        int lat; logic [31:0] f; logic ovf;
        send(24'h800000, 1'b0, 8'd127, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL one_lat got %0d want 1", lat); end
        vecs++; if (f !== 32'h3F800000) begin errs++; $display("FAIL one_oF got %h want 3f800000", f); end
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL one_ovf got %b want 0", ovf); end
        @(negedge iClk);
        vecs++; if (oValid !== 1'b0) begin errs++; $display("FAIL one_pulse got %b want 0", oValid); end
        vecs++; if (oReady !== 1'b1) begin errs++; $display("FAIL one_ready got %b want 1", oReady); end
    endtask

    task automatic test_carry;
        int lat; logic [31:0] f; logic ovf;
        send(24'h000000, 1'b1, 8'd127, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL carry_lat got %0d want 1", lat); end
        vecs++; if (f !== 32'h40000000) begin errs++; $display("FAIL carry_oF got %h want 40000000", f); end
    endtask

    task automatic test_shift_noise;
        int lat; logic [31:0] f; logic ovf; int extra;
        send(24'h100000, 1'b0, 8'd130, 1'b0, 1'b1, lat, f, ovf);
        vecs++; if (lat !== 4) begin errs++; $display("FAIL shift_lat got %0d want 4", lat); end
        vecs++; if (f !== 32'h3F800000) begin errs++; $display("FAIL shift_oF got %h want 3f800000", f); end
        extra = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge iClk);
            if (oValid) extra++;
        end
        vecs++; if (extra !== 0) begin errs++; $display("FAIL shift_ignored got %0d extra strobes want 0", extra); end
        vecs++; if (oF !== 32'h3F800000) begin errs++; $display("FAIL shift_hold got %h want 3f800000", oF); end
    endtask

    task automatic test_denormal;
        int lat; logic [31:0] f; logic ovf;
        send(24'h000001, 1'b0, 8'd10, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 10) begin errs++; $display("FAIL denorm_lat got %0d want 10", lat); end
        vecs++; if (f !== 32'h00000200) begin errs++; $display("FAIL denorm_oF got %h want 00000200", f); end
        send(24'h400000, 1'b0, 8'd1, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL denorm_e1_lat got %0d want 1", lat); end
        vecs++; if (f !== 32'h00400000) begin errs++; $display("FAIL denorm_e1_oF got %h want 00400000", f); end
        send(24'h400000, 1'b0, 8'd2, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 2) begin errs++; $display("FAIL floor_norm_lat got %0d want 2", lat); end
        vecs++; if (f !== 32'h00800000) begin errs++; $display("FAIL floor_norm_oF got %h want 00800000", f); end
    endtask

    task automatic test_max_shift;
        int lat; logic [31:0] f; logic ovf;
        send(24'h000001, 1'b0, 8'd100, 1'b1, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 24) begin errs++; $display("FAIL max_lat got %0d want 24", lat); end
        vecs++; if (f !== 32'hA6800000) begin errs++; $display("FAIL max_oF got %h want a6800000", f); end
    endtask

    task automatic test_ovf;
        int lat; logic [31:0] f; logic ovf;
        send(24'h123456, 1'b1, 8'd254, 1'b1, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL ovf_lat got %0d want 1", lat); end
        vecs++; if (f !== 32'hFF800000) begin errs++; $display("FAIL ovf_oF got %h want ff800000", f); end
        vecs++; if (ovf !== 1'b1) begin errs++; $display("FAIL ovf_flag got %b want 1", ovf); end
        repeat (3) @(negedge iClk);
        vecs++; if (oOvf !== 1'b1 || oF !== 32'hFF800000) begin
            errs++; $display("FAIL ovf_hold got %h/%b want ff800000/1", oF, oOvf);
        end
        send(24'h800000, 1'b0, 8'd127, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (ovf !== 1'b0) begin errs++; $display("FAIL ovf_clear got %b want 0", ovf); end
        vecs++; if (f !== 32'h3F800000) begin errs++; $display("FAIL ovf_next_oF got %h want 3f800000", f); end
        send(24'h800000, 1'b0, 8'd255, 1'b0, 1'b0, lat, f, ovf);
        vecs++; if (f !== 32'h7F800000 || ovf !== 1'b1) begin
            errs++; $display("FAIL e255 got %h/%b want 7f800000/1", f, ovf);
        end
    endtask

    task automatic test_zero;
        int lat; logic [31:0] f; logic ovf;
        send(24'h000000, 1'b0, 8'd50, 1'b1, 1'b0, lat, f, ovf);
        vecs++; if (lat !== 1) begin errs++; $display("FAIL zero_lat got %0d want 1", lat); end
        vecs++; if (f !== 32'h80000000) begin errs++; $display("FAIL zero_oF got %h want 80000000", f); end
    endtask

    task automatic test_back_to_back;
        @(negedge iClk);
        iValid = 1'b1; iS = 24'h800000; iC = 1'b0; iE = 8'd127; iSign = 1'b0;
        @(negedge iClk);
        vecs++; if (oValid !== 1'b1 || oReady !== 1'b0) begin
            errs++; $display("FAIL b2b_first got v=%b r=%b want v=1 r=0", oValid, oReady);
        end
        iS = 24'h000000; iC = 1'b1; iE = 8'd127;
        @(negedge iClk);
        vecs++; if (oValid !== 1'b0 || oReady !== 1'b1) begin
            errs++; $display("FAIL b2b_gap got v=%b r=%b want v=0 r=1", oValid, oReady);
        end
        @(negedge iClk);
        iValid = 1'b0;
        vecs++; if (oValid !== 1'b1 || oF !== 32'h40000000) begin
            errs++; $display("FAIL b2b_second got v=%b oF=%h want v=1 oF=40000000", oValid, oF);
        end
        @(negedge iClk);
    endtask

    task automatic test_reset_abort;
        int seen;
        @(negedge iClk);
        iValid = 1'b1; iS = 24'h000001; iC = 1'b0; iE = 8'd10; iSign = 1'b1;
        @(posedge iClk);
        #1 iValid = 1'b0;
        repeat (3) @(negedge iClk);
        vecs++; if (oReady !== 1'b0) begin errs++; $display("FAIL abort_busy got %b want 0", oReady); end
        iRst = 1'b1;
        @(posedge iClk);
        #1 iRst = 1'b0;
        @(negedge iClk);
        vecs++; if (oReady !== 1'b1) begin errs++; $display("FAIL abort_ready got %b want 1", oReady); end
        vecs++; if (oF !== 32'h0 || oOvf !== 1'b0) begin
            errs++; $display("FAIL abort_clear got %h/%b want 00000000/0", oF, oOvf);
        end
        seen = (oValid === 1'b1) ? 1 : 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge iClk);
            if (oValid !== 1'b0) seen++;
        end
        vecs++; if (seen !== 0) begin errs++; $display("FAIL abort_no_valid got %0d strobes want 0", seen); end
    endtask

    initial begin
        iRst = 1'b1; iValid = 1'b0; iS = 24'h0; iC = 1'b0; iE = 8'h0; iSign = 1'b0;
        test_reset();
        test_one();
        test_carry();
        test_shift_noise();
        test_denormal();
        test_max_shift();
        test_ovf();
        test_zero();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/add_norm_seq.md
ADD_NORM_SEQ -- requirements
Module: add_norm_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed (IEEE754 single: 24-bit significand, 8-bit biased exponent).
REQ-002 iClk  input  1  sole clock; all state changes on rising edge.
REQ-003 iRst  input  1  reset, synchronous, active-high.
REQ-004 iValid  input  1  request strobe; accepted only when oReady=1.
REQ-005 iS  input  24  raw significand sum from the 24-bit CLA adder (bit 23 = hidden-bit position).
REQ-006 iC  input  1  carry-out of the CLA adder.
REQ-007 iE  input  8  biased exponent of the aligned operands.
REQ-008 iSign  input  1  result sign.
REQ-009 oReady  output  1  high only in IDLE.
REQ-010 oValid  output  1  one-cycle result strobe.
REQ-011 oF  output  32  packed result {sign, exp[7:0], frac[22:0]}, truncation rounding.
REQ-012 oOvf  output  1  overflow flag, qualified by oValid.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE; internal registers mant[23:0], exp[7:0], sign.
REQ-014 IDLE, iValid=1: SHALL capture iSign and classify, priority order:
  a) iE=255, or iC=1 with iE=254 -> exp=255, mant=0, ovf=1, -> DONE;
  b) iC=1 -> mant={1'b1,iS[23:1]}, exp=iE+1, -> DONE (LSB iS[0] discarded);
  c) iS=0 -> exp=0, mant=0, -> DONE (signed zero);
  d) iS[23]=1 -> mant=iS, exp=iE, -> DONE;
  e) iE<=1 -> mant=iS, exp=0, -> DONE (denormal, no shift);
  f) otherwise mant=iS, exp=iE, -> SHIFT.
REQ-015 IDLE, iValid=0: SHALL remain in IDLE, registers unchanged.
REQ-016 SHIFT, each edge: mant<=mant<<1, exp<=exp-1; -> DONE if old mant[22]=1; else if exp-1=1 -> exp<=0 (denormal encoding), -> DONE; else stay in SHIFT.
REQ-017 SHIFT SHALL never be entered or held with exp<=1; at most 23 shift cycles.
REQ-018 DONE: oValid=1 for exactly one cycle; oF={sign,exp,mant[22:0]}, oOvf=ovf, registered on entry to DONE; -> IDLE next edge.
REQ-019 Latency: acceptance edge to oValid cycle = 1 + k cycles, k = shifts performed (0..23); minimum issue interval 2 cycles.
REQ-020 iValid while oReady=0 SHALL be ignored, with no effect on state or outputs.
REQ-021 oF and oOvf SHALL hold their last values outside DONE until the next DONE load.
REQ-022 ovf SHALL be cleared on every acceptance not classified as case a).
REQ-023 Exponent arithmetic SHALL be 8-bit unsigned; no wrap is reachable given REQ-014/016.

Reset
REQ-024 iRst=1 at an edge SHALL force IDLE, oValid=0, oF=32'h0, oOvf=0, internal registers 0; oReady=1 in the following cycle.
REQ-025 Reset SHALL take priority over iValid and over any SHIFT/DONE activity; an operation aborted by reset SHALL produce no oValid.

Verification
REQ-026 iS=24'h800000, iC=0, iE=127, iSign=0 -> oValid 1 cycle after accept, oF=32'h3F800000, oOvf=0.
REQ-027 iS=24'h000000, iC=1, iE=127 -> latency 1, oF=32'h40000000.
REQ-028 iS=24'h100000, iC=0, iE=130 -> 3 shifts, latency 4, oF=32'h3F800000; iValid pulses during SHIFT ignored.
REQ-029 iS=24'h000001, iC=0, iE=10 -> 9 shifts, latency 10, oF=32'h00000200 (denormal).
REQ-030 iC=1, iE=254, iSign=1 -> latency 1, oF=32'hFF800000, oOvf=1; a following normal request clears oOvf.
REQ-031 iS=0, iC=0, iSign=1 -> oF=32'h80000000; separately, iRst asserted during SHIFT -> no oValid, oReady=1 next cycle, oF=0.
